// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if: pipeline-side request/response and data-memory port bundle
interface mem_access_unit_if;
  logic        Mem_Read;
  logic        Mem_Write;
  logic [1:0]  Mem_Size;
  logic        Mem_Unsigned;
  logic [31:0] Address;
  logic [31:0] Store_Data;
  logic [31:0] Load_Data;
  logic        Stall;
  logic        Fault;
  logic        Fault_Valid;
  logic [31:0] Fault_Address;
  logic        Fault_Clear;
  logic [31:0] Dm_Address;
  logic        Dm_Write;
  logic [31:0] Dm_Write_Data;
  logic [31:0] Dm_Read_Data;
  modport master(
    output Mem_Read, Mem_Write, Mem_Size, Mem_Unsigned, Address, Store_Data, Fault_Clear, Dm_Read_Data,
    input  Load_Data, Stall, Fault, Fault_Valid, Fault_Address, Dm_Address, Dm_Write, Dm_Write_Data
  );
  modport slave(
    input  Mem_Read, Mem_Write, Mem_Size, Mem_Unsigned, Address, Store_Data, Fault_Clear, Dm_Read_Data,
    output Load_Data, Stall, Fault, Fault_Valid, Fault_Address, Dm_Address, Dm_Write, Dm_Write_Data
  );
endinterface

// File: rtl/mem_access_unit.sv
// mem_access_unit: sub-word load/store front end for a word-only data memory
module mem_access_unit #(
  parameter int MEM_WORDS   = 1024,
  parameter bit RANGE_CHECK = 1'b1
) (
  input logic Clk,
  input logic Reset,
  mem_access_unit_if.slave bus
);
  typedef enum logic {IDLE, RMW_WRITE} state_t;
  state_t      state;
  logic [29:0] r_addr;
  logic [31:0] r_data;
  logic [1:0]  r_size;
  logic [1:0]  r_lane;
  logic [31:0] merge_word;
  logic        fault_valid;
  logic [31:0] fault_address;
  logic        is_word, is_half, misaligned, out_of_range, idle, fault, store_ok, sub_store;
  logic [7:0]  lb;
  logic [15:0] lh;
  logic [4:0]  sh;
  logic [31:0] mask, merged;
  // request decode, lane extraction and read-modify-write merge
  always_comb begin
    is_word      = bus.Mem_Size[1];
    is_half      = bus.Mem_Size == 2'b01;
    misaligned   = (is_half & bus.Address[0]) | (is_word & |bus.Address[1:0]);
    out_of_range = RANGE_CHECK & ({2'b00, bus.Address[31:2]} >= 32'(MEM_WORDS));
    idle         = state == IDLE;
    fault        = idle & (bus.Mem_Read | bus.Mem_Write) & (misaligned | out_of_range);
    store_ok     = idle & bus.Mem_Write & ~fault & ~Reset;
    sub_store    = store_ok & ~is_word;
    lb           = bus.Dm_Read_Data[{bus.Address[1:0], 3'b000} +: 8];
    lh           = bus.Dm_Read_Data[{bus.Address[1], 4'b0000} +: 16];
    sh           = {r_lane, 3'b000};
    mask         = (r_size == 2'b00 ? 32'h0000_00FF : 32'h0000_FFFF) << sh;
    merged       = (merge_word & ~mask) | ((r_data << sh) & mask);
    bus.Load_Data     = fault ? 32'h0 : is_word ? bus.Dm_Read_Data :
                        is_half ? {{16{~bus.Mem_Unsigned & lh[15]}}, lh} : {{24{~bus.Mem_Unsigned & lb[7]}}, lb};
    bus.Fault         = fault;
    bus.Stall         = sub_store;
    bus.Dm_Write      = ~Reset & (idle ? store_ok & is_word : 1'b1);
    bus.Dm_Address    = idle ? {bus.Address[31:2], 2'b00} : {r_addr, 2'b00};
    bus.Dm_Write_Data = idle ? bus.Store_Data : merged;
    bus.Fault_Valid   = fault_valid;
    bus.Fault_Address = fault_address;
  end
  // RMW sequencing, captured store context and sticky first-fault record
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state         <= IDLE;
      r_addr        <= '0;
      r_data        <= '0;
      r_size        <= '0;
      r_lane        <= '0;
      merge_word    <= '0;
      fault_valid   <= 1'b0;
      fault_address <= '0;
    end else begin
      state <= sub_store ? RMW_WRITE : IDLE;
      if (sub_store) begin
        r_addr     <= bus.Address[31:2];
        r_data     <= bus.Store_Data;
        r_size     <= bus.Mem_Size;
        r_lane     <= bus.Address[1:0];
        merge_word <= bus.Dm_Read_Data;
      end
      if (bus.Fault_Clear) begin
        fault_valid   <= 1'b0;
        fault_address <= '0;
      end else if (fault & ~fault_valid) begin
        fault_valid   <= 1'b1;
        fault_address <= bus.Address;
      end
    end
  end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed scoreboard bench for the load/store front end
module tb_mem_access_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int cyc = 0;
  int compared = 0;
  int mismatched = 0;
  logic [31:0] mem [0:1023];
  typedef struct {
    int cyc; string nm;
    bit cc, cl, cw, cm;
    logic [31:0] ld, wd, fa, mv;
    logic st, ft, f2, dw, fv;
    int mi;
  } exp_t;
  exp_t q[$];
  mem_access_unit_if a();
  mem_access_unit_if b();
  mem_access_unit #(.MEM_WORDS(1024), .RANGE_CHECK(1'b1)) dut (.Clk(clk), .Reset(rst), .bus(a.slave));
  mem_access_unit #(.MEM_WORDS(1024), .RANGE_CHECK(1'b0)) dut_nr (.Clk(clk), .Reset(rst), .bus(b.slave));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign a.Dm_Read_Data = mem[a.Dm_Address[11:2]];
  assign b.Mem_Read     = a.Mem_Read;
  assign b.Mem_Write    = a.Mem_Write;
  assign b.Mem_Size     = a.Mem_Size;
  assign b.Mem_Unsigned = a.Mem_Unsigned;
  assign b.Address      = a.Address;
  assign b.Store_Data   = a.Store_Data;
  assign b.Fault_Clear  = a.Fault_Clear;
  assign b.Dm_Read_Data = 32'h0;
  always @(posedge clk) if (a.Dm_Write) mem[a.Dm_Address[11:2]] <= a.Dm_Write_Data;
  task automatic chk(string nm, string f, logic [31:0] act, logic [31:0] exv);
    compared++;
    if (act !== exv) begin
      mismatched++;
      $display("FAIL %s.%s got %h expected %h (cycle %0d)", nm, f, act, exv, cyc);
    end
  endtask
  // monitor: pops every expectation due this cycle and compares it against the DUT
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      exp_t e;
      e = q.pop_front();
      if (e.cyc < cyc) begin
        chk(e.nm, "late", cyc, e.cyc);
      end else begin
        if (e.cl) chk(e.nm, "load_data", a.Load_Data, e.ld);
        if (e.cw) chk(e.nm, "dm_write_data", a.Dm_Write_Data, e.wd);
        if (e.cm) chk(e.nm, "mem", mem[e.mi], e.mv);
        if (e.cc) begin
          chk(e.nm, "stall", {31'b0, a.Stall}, {31'b0, e.st});
          chk(e.nm, "fault", {31'b0, a.Fault}, {31'b0, e.ft});
          chk(e.nm, "fault_nr", {31'b0, b.Fault}, {31'b0, e.f2});
          chk(e.nm, "dm_write", {31'b0, a.Dm_Write}, {31'b0, e.dw});
          chk(e.nm, "fault_valid", {31'b0, a.Fault_Valid}, {31'b0, e.fv});
          chk(e.nm, "fault_address", a.Fault_Address, e.fa);
        end
      end
    end
  end
  task automatic go(bit r, bit rd, bit wr, logic [1:0] sz, bit u, logic [31:0] ad, logic [31:0] sd, bit clr);
    @(posedge clk);
    #1;
    rst = r;
    a.Mem_Read = rd;
    a.Mem_Write = wr;
    a.Mem_Size = sz;
    a.Mem_Unsigned = u;
    a.Address = ad;
    a.Store_Data = sd;
    a.Fault_Clear = clr;
  endtask
  task automatic ex(string nm, logic [31:0] ld, bit cl, bit st, bit ft, bit f2, bit dw,
                    logic [31:0] wd, bit cw, bit fv, logic [31:0] fa);
    exp_t e;
    e = '{cyc: cyc, nm: nm, cc: 1'b1, cl: cl, cw: cw, cm: 1'b0, ld: ld, wd: wd, fa: fa, mv: 32'h0,
          st: st, ft: ft, f2: f2, dw: dw, fv: fv, mi: 0};
    q.push_back(e);
  endtask
  task automatic exm(string nm, int mi, logic [31:0] mv);
    exp_t e;
    e = '{cyc: cyc, nm: nm, cc: 1'b0, cl: 1'b0, cw: 1'b0, cm: 1'b1, ld: 32'h0, wd: 32'h0, fa: 32'h0, mv: mv,
          st: 1'b0, ft: 1'b0, f2: 1'b0, dw: 1'b0, fv: 1'b0, mi: mi};
    q.push_back(e);
  endtask
  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    mem[4] = 32'h8899AABB;
    mem[9] = 32'hAABBCCDD;
    go(1, 0, 0, 2'b10, 0, 32'h0, 32'h0, 0);
    go(1, 0, 0, 2'b10, 0, 32'h0, 32'h0, 0);
    ex("reset", 32'h0, 1, 0, 0, 0, 0, 32'h0, 0, 0, 32'h0);
    go(0, 1, 0, 2'b00, 0, 32'h13, 32'h0, 0);
    ex("lb13", 32'hFFFFFF88, 1, 0, 0, 0, 0, 32'h0, 0, 0, 32'h0);
    go(0, 1, 0, 2'b00, 1, 32'h13, 32'h0, 0);
    ex("lbu13", 32'h00000088, 1, 0, 0, 0, 0, 32'h0, 0, 0, 32'h0);
    go(0, 1, 0, 2'b01, 1, 32'h12, 32'h0, 0);
    ex("lhu12", 32'h00008899, 1, 0, 0, 0, 0, 32'h0, 0, 0, 32'h0);
    go(0, 1, 0, 2'b01, 0, 32'h12, 32'h0, 0);
    ex("lh12", 32'hFFFF8899, 1, 0, 0, 0, 0, 32'h0, 0, 0, 32'h0);
    go(0, 1, 0, 2'b00, 0, 32'h10, 32'h0, 0);
    ex("lb10", 32'hFFFFFFBB, 1, 0, 0, 0, 0, 32'h0, 0, 0, 32'h0);
    go(0, 1, 0, 2'b00, 1, 32'h11, 32'h0, 0);
    ex("lbu11", 32'h000000AA, 1, 0, 0, 0, 0, 32'h0, 0, 0, 32'h0);
    go(0, 0, 1, 2'b10, 0, 32'h20, 32'h12345678, 0);
    ex("sw20", 32'h0, 0, 0, 0, 0, 1, 32'h12345678, 1, 0, 32'h0);
    go(0, 1, 0, 2'b10, 0, 32'h20, 32'h0, 0);
    ex("lw20", 32'h12345678, 1, 0, 0, 0, 0, 32'h0, 0, 0, 32'h0);
    go(0, 1, 1, 2'b11, 0, 32'h30, 32'hCAFEF00D, 0);
    ex("rw30", 32'h0, 1, 0, 0, 0, 1, 32'hCAFEF00D, 1, 0, 32'h0);
    go(0, 1, 0, 2'b10, 0, 32'h30, 32'h0, 0);
    ex("lw30", 32'hCAFEF00D, 1, 0, 0, 0, 0, 32'h0, 0, 0, 32'h0);
    go(0, 0, 1, 2'b00, 0, 32'h25, 32'hDEADBE11, 0);
    ex("sb25_c0", 32'h0, 0, 1, 0, 0, 0, 32'h0, 0, 0, 32'h0);
    go(0, 0, 1, 2'b00, 0, 32'h25, 32'hDEADBE11, 0);
    ex("sb25_c1", 32'h0, 0, 0, 0, 0, 1, 32'hAABB11DD, 1, 0, 32'h0);
    go(0, 1, 0, 2'b10, 0, 32'h24, 32'h0, 0);
    ex("lw24_sb", 32'hAABB11DD, 1, 0, 0, 0, 0, 32'h0, 0, 0, 32'h0);
    go(0, 0, 1, 2'b01, 0, 32'h26, 32'h12347788, 0);
    mem[9] = 32'hAABBCCDD;
    ex("sh26_c0", 32'h0, 0, 1, 0, 0, 0, 32'h0, 0, 0, 32'h0);
    go(0, 0, 1, 2'b01, 0, 32'h26, 32'h12347788, 0);
    ex("sh26_c1", 32'h0, 0, 0, 0, 0, 1, 32'h7788CCDD, 1, 0, 32'h0);
    go(0, 1, 0, 2'b10, 0, 32'h24, 32'h0, 0);
    ex("lw24_sh", 32'h7788CCDD, 1, 0, 0, 0, 0, 32'h0, 0, 0, 32'h0);
    go(0, 1, 0, 2'b10, 0, 32'h22, 32'h0, 0);
    ex("lw22_mis", 32'h0, 1, 0, 1, 1, 0, 32'h0, 0, 0, 32'h0);
    go(0, 0, 1, 2'b10, 0, 32'h1001, 32'hFFFFFFFF, 0);
    ex("sw1001", 32'h0, 1, 0, 1, 1, 0, 32'h0, 0, 1, 32'h22);
    go(0, 0, 0, 2'b10, 0, 32'h0, 32'h0, 1);
    ex("clr", 32'h0, 0, 0, 0, 0, 0, 32'h0, 0, 1, 32'h22);
    go(0, 0, 0, 2'b10, 0, 32'h0, 32'h0, 0);
    ex("cleared", 32'h0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 32'h0);
    go(0, 1, 0, 2'b10, 0, 32'h22, 32'h0, 1);
    ex("clr_prio", 32'h0, 1, 0, 1, 1, 0, 32'h0, 0, 0, 32'h0);
    go(0, 0, 0, 2'b10, 0, 32'h0, 32'h0, 0);
    ex("clr_won", 32'h0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 32'h0);
    go(0, 1, 0, 2'b01, 0, 32'h13, 32'h0, 0);
    ex("lh13_mis", 32'h0, 1, 0, 1, 1, 0, 32'h0, 0, 0, 32'h0);
    go(0, 0, 0, 2'b10, 0, 32'h0, 32'h0, 1);
    ex("fv13", 32'h0, 0, 0, 0, 0, 0, 32'h0, 0, 1, 32'h13);
    go(0, 1, 0, 2'b10, 0, 32'hFFC, 32'h0, 0);
    ex("lw_ffc", 32'h0, 1, 0, 0, 0, 0, 32'h0, 0, 0, 32'h0);
    go(0, 1, 0, 2'b10, 0, 32'h1000, 32'h0, 0);
    ex("lw1000", 32'h0, 1, 0, 1, 0, 0, 32'h0, 0, 0, 32'h0);
    go(0, 0, 1, 2'b10, 0, 32'h1000, 32'hFFFFFFFF, 0);
    ex("sw1000", 32'h0, 0, 0, 1, 0, 0, 32'h0, 0, 1, 32'h1000);
    go(0, 0, 1, 2'b00, 0, 32'h25, 32'h55, 0);
    ex("sb_rst_c0", 32'h0, 0, 1, 0, 0, 0, 32'h0, 0, 1, 32'h1000);
    go(1, 0, 1, 2'b00, 0, 32'h25, 32'h55, 0);
    ex("sb_rst_c1", 32'h0, 0, 0, 0, 0, 0, 32'h0, 0, 1, 32'h1000);
    go(0, 1, 0, 2'b10, 0, 32'h24, 32'h0, 0);
    ex("after_rst", 32'h7788CCDD, 1, 0, 0, 0, 0, 32'h0, 0, 0, 32'h0);
    exm("mem24", 9, 32'h7788CCDD);
    go(0, 0, 1, 2'b10, 0, 32'h40, 32'h00000001, 0);
    ex("sw40_idle", 32'h0, 0, 0, 0, 0, 1, 32'h00000001, 1, 0, 32'h0);
    go(0, 0, 0, 2'b10, 0, 32'h0, 32'h0, 0);
    exm("mem40", 16, 32'h00000001);
    repeat (3) @(negedge clk);
    if (q.size() != 0) begin
      compared++;
      mismatched++;
      $display("FAIL scoreboard %0d entries left, 0 required", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
